btn_debounce_nexys: RTL

Debounces and synchronizes the five Nexys A7 push-buttons (BTNC, BTNU, BTNL, BTNR, BTND) in the core clock domain. It sits directly upstream of the SweRVolf GPIO button bank, replacing the raw pad connections on `io_data2[31:27]`. Per button it provides:

- a clean level;
- one-cycle press and release pulses;
- a sticky press-event flag that firmware clears per bit.

---
 rtl/btn_debounce_pkg.sv | 10 +
 rtl/btn_debounce_ch.sv | 62 ++++++
 rtl/btn_debounce_nexys.sv | 29 ++
 3 files changed

// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg: shared state encoding, button indices and default debounce length
package btn_debounce_pkg;
   typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} db_state_t;
   localparam int BTN_C = 4;
   localparam int BTN_U = 3;
   localparam int BTN_L = 2;
   localparam int BTN_R = 1;
   localparam int BTN_D = 0;
   localparam int DEBOUNCE_DEFAULT = 1_000_000;
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel with synchronizer, debounce FSM, edge pulses and sticky press flag
module btn_debounce_ch
   import btn_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   input  logic i_clr,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_event
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic s1, s2;
   db_state_t st;
   logic [CW-1:0] cnt;
   logic done, press_nx, release_nx;
   assign done = cnt == LAST;
   assign press_nx = st == CHK_HI && s2 && done;
   assign release_nx = st == CHK_LO && !s2 && done;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         st <= STABLE_LO;
         cnt <= '0;
         o_level <= 1'b0;
         o_press <= 1'b0;
         o_release <= 1'b0;
         o_event <= 1'b0;
      end else begin
         s1 <= i_btn;
         s2 <= s1;
         o_press <= press_nx;
         o_release <= release_nx;
         o_level <= press_nx | (o_level & ~release_nx);
         o_event <= (o_event & ~i_clr) | press_nx;
         case (st)
            STABLE_LO: if (s2) begin
               st <= CHK_HI;
               cnt <= CW'(1);
            end
            CHK_HI: begin
               st <= !s2 ? STABLE_LO : done ? STABLE_HI : CHK_HI;
               cnt <= (!s2 || done) ? '0 : cnt + 1'b1;
            end
            STABLE_HI: if (!s2) begin
               st <= CHK_LO;
               cnt <= CW'(1);
            end
            default: begin
               st <= s2 ? STABLE_HI : done ? STABLE_LO : CHK_LO;
               cnt <= (s2 || done) ? '0 : cnt + 1'b1;
            end
         endcase
      end
   end
endmodule

// File: rtl/btn_debounce_nexys.sv
// btn_debounce_nexys: debounced, synchronized Nexys A7 push-button bank {C,U,L,R,D}
module btn_debounce_nexys
   import btn_debounce_pkg::*;
#(
   parameter int NUM_BTN = 5,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_BTN-1:0] i_btn,
   input  logic [NUM_BTN-1:0] i_clr,
   output logic [NUM_BTN-1:0] o_level,
   output logic [NUM_BTN-1:0] o_press,
   output logic [NUM_BTN-1:0] o_release,
   output logic [NUM_BTN-1:0] o_event
);
   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      btn_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_btn    (i_btn[g]),
         .i_clr    (i_clr[g]),
         .o_level  (o_level[g]),
         .o_press  (o_press[g]),
         .o_release(o_release[g]),
         .o_event  (o_event[g])
      );
   end
endmodule
